// File: rtl/multi_channel_reduce.sv
// multi_channel_reduce: per-channel sum plus selectable AND/OR/XOR/MAX reduction behind a 2-stage valid/ready pipeline
module multi_channel_reduce #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SUM_W    = WIDTH + $clog2(CHANNELS),
  parameter int CNT_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SUM_W-1:0]          out_sum,
  output logic [WIDTH-1:0]          out_red,
  output logic [1:0]                out_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          xfer_count
);
  typedef enum logic [1:0] {MODE_AND, MODE_OR, MODE_XOR, MODE_MAX} mode_e;
  logic [CHANNELS*WIDTH-1:0] r_s1_data;
  logic [1:0]                r_s1_mode;
  logic                      r_s1_valid;
  logic [SUM_W-1:0]          r_sum;
  logic [WIDTH-1:0]          r_red;
  logic [1:0]                r_mode;
  logic                      r_valid;
  logic [CNT_W-1:0]          r_count;
  logic                      w_s1_adv;
  logic                      w_in_hs;
  logic                      w_out_hs;
  logic [SUM_W-1:0]          w_sum;
  logic [WIDTH-1:0]          w_and;
  logic [WIDTH-1:0]          w_or;
  logic [WIDTH-1:0]          w_xor;
  logic [WIDTH-1:0]          w_max;
  logic [WIDTH-1:0]          w_red;
  assign w_out_hs   = r_valid && out_ready;
  assign w_s1_adv   = r_s1_valid && (!r_valid || out_ready);
  assign in_ready   = !reset && (!r_s1_valid || w_s1_adv);
  assign w_in_hs    = in_valid && in_ready;
  assign out_sum    = r_sum;
  assign out_red    = r_red;
  assign out_mode   = r_mode;
  assign out_valid  = r_valid;
  assign xfer_count = r_count;
  // reduce the captured word across all channels; every result is computed and the mode picks one
  always_comb begin
    w_sum = '0;
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    w_max = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum = w_sum + SUM_W'(r_s1_data[k*WIDTH +: WIDTH]);
      w_and = w_and & r_s1_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | r_s1_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ r_s1_data[k*WIDTH +: WIDTH];
      w_max = (r_s1_data[k*WIDTH +: WIDTH] > w_max) ? r_s1_data[k*WIDTH +: WIDTH] : w_max;
    end
    w_red = (r_s1_mode == MODE_AND) ? w_and :
            (r_s1_mode == MODE_OR)  ? w_or  :
            (r_s1_mode == MODE_XOR) ? w_xor : w_max;
  end
  // capture stage: data only loads on a handshake so idle-cycle garbage never enters the pipe
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_data  <= '0;
      r_s1_mode  <= '0;
      r_s1_valid <= 1'b0;
    end else if (w_in_hs) begin
      r_s1_data  <= in_data;
      r_s1_mode  <= in_mode;
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end
  // output stage: holds its result while stalled, reloads on the same edge the old one is consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum   <= '0;
      r_red   <= '0;
      r_mode  <= '0;
      r_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_sum   <= w_sum;
      r_red   <= w_red;
      r_mode  <= r_s1_mode;
      r_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end
  // count consumed results, wrapping silently
  always_ff @(posedge clock) begin
    if (reset) r_count <= '0;
    else if (w_out_hs) r_count <= r_count + 1'b1;
  end
endmodule

// File: tb/tb_multi_channel_reduce.sv
// tb_multi_channel_reduce: randomized and directed checks against a queue-based reference model
module tb_multi_channel_reduce;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        in_valid;
  logic        in_ready, w_in_ready;
  logic [9:0]  out_sum, w_out_sum;
  logic [7:0]  out_red, w_out_red;
  logic [1:0]  out_mode, w_out_mode;
  logic        out_valid, w_out_valid;
  logic        out_ready;
  logic [15:0] xfer_count;
  logic [3:0]  w_xfer_count;
  typedef struct {
    int         s;
    logic [7:0] r;
    logic [1:0] m;
  } res_t;
  res_t        exp_q[$];
  logic [15:0] m_count;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        hold;
  logic [9:0]  h_sum;
  logic [7:0]  h_red;
  logic [1:0]  h_mode;
  always #5 clock = ~clock;
  multi_channel_reduce u_dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready), .out_sum(out_sum), .out_red(out_red), .out_mode(out_mode),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count));
  multi_channel_reduce #(.CNT_W(4)) u_wrap (
    .clock(clock), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(w_in_ready), .out_sum(w_out_sum), .out_red(w_out_red), .out_mode(w_out_mode),
    .out_valid(w_out_valid), .out_ready(out_ready), .xfer_count(w_xfer_count));
  function automatic res_t model(input logic [31:0] d, input logic [1:0] m);
    res_t       res;
    int         s;
    int         mx;
    logic [7:0] a, o, x;
    s = 0; mx = 0; a = 8'hff; o = 8'h00; x = 8'h00;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] v;
      v = d[k*8 +: 8];
      s += int'(v);
      a &= v;
      o |= v;
      x ^= v;
      if (int'(v) > mx) mx = int'(v);
    end
    res.s = s;
    res.m = m;
    case (m)
      2'd0: res.r = a;
      2'd1: res.r = o;
      2'd2: res.r = x;
      default: res.r = 8'(mx);
    endcase
    return res;
  endfunction
  function automatic logic [31:0] pack(input logic [7:0] c3, input logic [7:0] c2, input logic [7:0] c1, input logic [7:0] c0);
    return {c3, c2, c1, c0};
  endfunction
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  // scoreboard: inputs are stable here, so this sees exactly what the next edge will do
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL in_ready_in_reset got=%b want=0", in_ready); end
      exp_q.delete();
      m_count = '0;
      hold = 1'b0;
    end else begin
      n_cmp++;
      if (xfer_count !== m_count) begin n_err++; $display("FAIL xfer_count got=%0d want=%0d", xfer_count, m_count); end
      n_cmp++;
      if (w_xfer_count !== m_count[3:0]) begin n_err++; $display("FAIL wrap_count got=%0d want=%0d", w_xfer_count, m_count[3:0]); end
      n_cmp++;
      if (in_ready !== (exp_q.size() < 2 || out_ready)) begin n_err++; $display("FAIL in_ready got=%b want=%b", in_ready, (exp_q.size() < 2 || out_ready)); end
      if (exp_q.size() == 0) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL spurious_out_valid got=%b want=0", out_valid); end
      end
      if (hold && out_valid) begin
        n_cmp++;
        if (out_sum !== h_sum || out_red !== h_red || out_mode !== h_mode) begin
          n_err++; $display("FAIL held_stable got=%0d/%0d/%0d want=%0d/%0d/%0d", out_sum, out_red, out_mode, h_sum, h_red, h_mode);
        end
      end
      hold = out_valid && !out_ready;
      h_sum = out_sum; h_red = out_red; h_mode = out_mode;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL extra_result got=%0d/%0d want=none", out_sum, out_red);
        end else begin
          if (int'(out_sum) != exp_q[0].s || out_red !== exp_q[0].r || out_mode !== exp_q[0].m) begin
            n_err++; $display("FAIL result got=%0d/%0d/%0d want=%0d/%0d/%0d", out_sum, out_red, out_mode, exp_q[0].s, exp_q[0].r, exp_q[0].m);
          end
          void'(exp_q.pop_front());
        end
        m_count = m_count + 1'b1;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
    end
  end
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++;
    if ({out_valid, out_sum, out_red, out_mode} !== '0 || xfer_count !== '0) begin
      n_err++; $display("FAIL reset_state got=v%b s%0d r%0d m%0d c%0d want=all 0", out_valid, out_sum, out_red, out_mode, xfer_count);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_basic();
    in_data = pack(8'd5, 8'd12, 8'd20, 8'd10); in_mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got=%b want=0", out_valid); end
    cyc();
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 10'd47 || out_red !== 8'd0) begin
      n_err++; $display("FAIL basic_and got=v%b s%0d r%0d want=v1 s47 r0", out_valid, out_sum, out_red);
    end
    cyc();
    n_cmp++;
    if (xfer_count !== 16'd1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_count got=c%0d v%b want=c1 v0", xfer_count, out_valid);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] d[3];
    int          es[3];
    int          er[3];
    d[0] = pack(8'd5, 8'd12, 8'd20, 8'd10);
    d[1] = pack(8'd50, 8'd112, 8'd30, 8'd20);
    d[2] = pack(8'd54, 8'd90, 8'd21, 8'd20);
    es = '{47, 212, 185};
    er = '{31, 72, 90};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin in_data = d[i]; in_mode = 2'(i + 1); end
      cyc();
      if (i > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || int'(out_sum) != es[i-1] || int'(out_red) != er[i-1] || out_mode !== 2'(i)) begin
          n_err++; $display("FAIL b2b_%0d got=v%b s%0d r%0d m%0d want=v1 s%0d r%0d m%0d", i-1, out_valid, out_sum, out_red, out_mode, es[i-1], er[i-1], i);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask
  task automatic test_extremes();
    logic [7:0] vals[2];
    int         es[2];
    vals = '{8'd255, 8'd55};
    es = '{1020, 220};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = {4{vals[i]}}; in_mode = 2'b00; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || int'(out_sum) != es[i] || out_red !== vals[i]) begin
        n_err++; $display("FAIL extreme_%0d got=v%b s%0d r%0d want=v1 s%0d r%0d", i, out_valid, out_sum, out_red, es[i], vals[i]);
      end
      cyc();
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] w[3];
    res_t        r[3];
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      w[i][7:0] = 8'(i);
      r[i] = model(w[i], 2'b11);
    end
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      in_data = w[(i < 2) ? i : 2];
      cyc();
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1 || int'(out_sum) != r[0].s || out_red !== r[0].r) begin
      n_err++; $display("FAIL bp_hold_a got=v%b s%0d r%0d want=v1 s%0d r%0d", out_valid, out_sum, out_red, r[0].s, r[0].r);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || int'(out_sum) != r[i].s || out_red !== r[i].r) begin
        n_err++; $display("FAIL bp_order_%0d got=v%b s%0d r%0d want=v1 s%0d r%0d", i, out_valid, out_sum, out_red, r[i].s, r[i].r);
      end
      cyc();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%b want=0", out_valid); end
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom | 32'h0101_0101;
      cyc();
    end
    reset = 1'b1; in_valid = 1'b0;
    cyc();
    n_cmp++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_red !== '0 || xfer_count !== '0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got=v%b s%0d r%0d c%0d rdy%b want=v0 s0 r0 c0 rdy0", out_valid, out_sum, out_red, xfer_count, in_ready);
    end
    reset = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got=%b want=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL stale_output cyc=%0d got=%b want=0", i, out_valid); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      in_mode = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL random_drain got=pending%0d v%b want=pending0 v0", exp_q.size(), out_valid);
    end
  endtask
  task automatic test_wrap();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = $urandom; in_mode = 2'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    n_cmp++;
    if (w_xfer_count !== 4'd1) begin n_err++; $display("FAIL wrap_17 got=%0d want=1", w_xfer_count); end
    n_cmp++;
    if (xfer_count !== 16'd17) begin n_err++; $display("FAIL count_17 got=%0d want=17", xfer_count); end
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    m_count = '0; hold = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_channel_reduce.md
Name: multi_channel_reduce

Overview:
- Parametrised successor to the four-register sum/AND datapath. It registers CHANNELS input words of WIDTH bits.
- It produces a full-precision sum and one selectable bitwise or compare reduction. The result is delivered through a 2-stage valid/ready pipeline with backpressure.
- It sits between upstream capture logic and downstream consumers. Downstream can stall; no data is lost or duplicated.

Parameters:
- WIDTH, 8, bits per channel word
- CHANNELS, 4, number of input channels (>=2)
- SUM_W, WIDTH+$clog2(CHANNELS), width of out_sum (derived; never overridden)
- CNT_W, 16, width of the transfer counter

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_mode  input  2  reduction select: 00 AND, 01 OR, 10 XOR, 11 unsigned MAX
- in_valid  input  1  upstream word set valid
- in_ready  output  1  block accepts in_data/in_mode this cycle
- out_sum  output  SUM_W  unsigned sum of all channels
- out_red  output  WIDTH  selected reduction result
- out_mode  output  2  mode the result was computed with
- out_valid  output  1  out_* valid
- out_ready  input  1  downstream accepts result
- xfer_count  output  CNT_W  number of results consumed since reset

Behaviour:
- Reset (synchronous, active-high; applies on any rising edge with reset=1, including mid-transfer):
  - All pipeline registers, out_sum, out_red, out_mode, out_valid and xfer_count go to 0.
  - In-flight data is discarded.
  - in_ready=0 while reset=1.
- Stage 1 (capture):
  - Holds s1_data, s1_mode and s1_valid.
  - An input handshake occurs when in_valid && in_ready.
  - in_ready = !reset && (!s1_valid || s1_adv), where s1_adv = s1_valid && (!out_valid || out_ready).
- Stage 2 (output):
  - On s1_adv, out_sum, out_red, out_mode and out_valid=1 load from the stage-1 contents.
  - If out_valid && out_ready and no s1_adv, out_valid clears to 0.
- Latency:
  - Input accepted at edge N -> result visible with out_valid=1 after edge N+1.
  - Throughput is 1 result per cycle when out_ready=1 continuously.
- Backpressure:
  - While out_valid && !out_ready, out_* are held stable.
  - Stage 1 holds one further word; once both stages are full, in_ready=0.
  - When out_ready returns, the buffered word moves to the output on the same edge the old result is consumed. No bubble and no loss.
- Simultaneous events:
  - Output consume, stage-1 advance and new input capture may all occur on one edge.
- Arithmetic:
  - out_sum is the unsigned sum, zero-extended to SUM_W; it never overflows.
  - out_red is the bitwise AND/OR/XOR across all channels, or the unsigned maximum channel value.
  - Mode is sampled with its data word. Changing in_mode while data is stalled has no effect on captured words.
- xfer_count:
  - Increments on each out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- in_data is ignored when in_valid=0. No X from in_data propagates while s1_valid=0.

Test Plan:
- Basic sum/AND:
  - Stimulus: after reset, in_data={5,12,20,10} (ch3..ch0), mode=00, out_ready=1.
  - Response: one cycle after accept, out_sum=47, out_red=0, out_valid=1, xfer_count=1 one edge later.
- OR/XOR/MAX back-to-back:
  - Stimulus: three consecutive words:
    - {5,12,20,10} with mode 01
    - {50,112,30,20} with mode 10
    - {54,90,21,20} with mode 11
  - Response: out_red=31, then 72, then 90 on consecutive cycles; out_sum=47, 212, 185; no bubbles.
- Width extremes:
  - Stimulus: all channels 255, mode=00.
  - Response: out_sum=1020 (10 bits), out_red=255.
  - Stimulus: all channels 55.
  - Response: out_sum=220, out_red=55.
- Backpressure:
  - Stimulus: hold out_ready=0 for 4 cycles while in_valid=1 with distinct words A, B, C.
  - Response: A is held on the output; B is captured; in_ready=0 thereafter; C is not accepted.
  - Stimulus: raise out_ready.
  - Response: A, B, C are delivered in order, exactly once each.
- Reset mid-operation:
  - Stimulus: assert reset for one cycle with both stages full.
  - Response: next cycle out_valid=0, out_sum=0, out_red=0, xfer_count=0, in_ready=1 once reset=0; stale words are never output.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 consumed results.
  - Response: xfer_count reads 1.
